// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - sequencing FSM for the multi-cycle RV32 datapath
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [6:0]             opcode_i,
  input  logic                   zero_i,
  input  logic                   mem_ready_i,
  output logic                   pc_write_o,
  output logic                   ir_write_o,
  output logic                   adr_src_o,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  output logic                   reg_write_o,
  output logic [1:0]             alu_src_a_o,
  output logic [1:0]             alu_src_b_o,
  output logic [1:0]             alu_op_o,
  output logic [1:0]             result_src_o,
  output logic [3:0]             state_o,
  output logic                   trap_o,
  output logic [1:0]             cause_o,
  output logic [COUNT_WIDTH-1:0] instret_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t              state;
  state_t              next_state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [1:0]          cause;
  logic [COUNT_WIDTH-1:0] instret;
  logic                is_wait;
  logic                timeout;
  logic                retire;

  // The last tolerated not-ready cycle is MEM_TIMEOUT-1; one more traps.
  assign is_wait = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout = is_wait && !mem_ready_i && (wait_cnt == WAIT_LAST);
  assign retire  = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                   ((state == S_MEMWR) && mem_ready_i);

  // Next-state selection; a memory timeout overrides the normal successor.
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (mem_ready_i) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          default:      next_state = S_TRAP;
        endcase
      end
      S_MEMADR: next_state = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready_i) next_state = S_MEMWB;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  if (mem_ready_i) next_state = S_FETCH;
      S_EXECR:  next_state = S_ALUWB;
      S_EXECI:  next_state = S_ALUWB;
      S_ALUWB:  next_state = S_FETCH;
      S_BEQ:    next_state = S_FETCH;
      S_JAL:    next_state = S_ALUWB;
      S_TRAP:   next_state = S_TRAP;
      default:  next_state = S_TRAP;
    endcase
    if (timeout) next_state = S_TRAP;
  end

  // State, wait counter, trap cause and retired-instruction counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      cause    <= 2'b00;
      instret  <= '0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        wait_cnt <= '0;
      end else if (is_wait && !mem_ready_i) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout) begin
        cause <= 2'b10;
      end else if ((state == S_DECODE) && (next_state == S_TRAP)) begin
        cause <= 2'b01;
      end
      if (retire) instret <= instret + 1'b1;
    end
  end

  // Control word decoded from the current state; enables are gated off during reset.
  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    adr_src_o    = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    result_src_o = 2'b00;
    case (state)
      S_FETCH: begin
        mem_read_o   = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
      end
      S_MEMRD: begin
        mem_read_o = 1'b1;
        adr_src_o  = 1'b1;
      end
      S_MEMWB: begin
        reg_write_o  = 1'b1;
        result_src_o = 2'b01;
      end
      S_MEMWR: begin
        mem_write_o = 1'b1;
        adr_src_o   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op_o    = 2'b10;
      end
      S_ALUWB: reg_write_o = 1'b1;
      S_BEQ: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b01;
        pc_write_o  = zero_i;
      end
      S_JAL: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write_o  = 1'b1;
      end
      default: ;
    endcase
    if (reset_i) begin
      pc_write_o  = 1'b0;
      ir_write_o  = 1'b0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      reg_write_o = 1'b0;
    end
  end

  assign state_o   = state;
  assign trap_o    = (state == S_TRAP);
  assign cause_o   = cause;
  assign instret_o = instret;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller
module tb_multicycle_controller;

  localparam int T  = 4;
  localparam int CW = 8;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RR  = 7'b0110011;
  localparam logic [6:0] II  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;

  logic clk_i = 1'b0;
  logic reset_i;
  logic [6:0] opcode_i;
  logic zero_i;
  logic mem_ready_i;
  logic pc_write_o, ir_write_o, adr_src_o, mem_read_o, mem_write_o, reg_write_o;
  logic [1:0] alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o;
  logic [3:0] state_o;
  logic trap_o;
  logic [1:0] cause_o;
  logic [CW-1:0] instret_o;

  multicycle_controller #(.MEM_TIMEOUT(T), .COUNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .opcode_i(opcode_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .ir_write_o(ir_write_o),
    .adr_src_o(adr_src_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_op_o(alu_op_o), .result_src_o(result_src_o), .state_o(state_o),
    .trap_o(trap_o), .cause_o(cause_o), .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // model: expected state this cycle, retired count, trap cause
  int        exp_st;
  bit        exp_reset;
  bit        chk_en;
  logic [CW-1:0] m_instret;
  logic [1:0]    m_cause;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, req);
    end
  endtask

  // control word {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, a, b, op, result_src}
  function automatic logic [14:0] exp_ctrl(input int st, input bit rdy, input bit z);
    logic pw, iw, adr, mrd, mwr, rw;
    logic [1:0] a, b, op, rs;
    {pw, iw, adr, mrd, mwr, rw} = 6'b0;
    a = 2'd0; b = 2'd0; op = 2'd0; rs = 2'd0;
    case (st)
      0:  begin pw = rdy; iw = rdy; mrd = 1; b = 2; rs = 2; end
      1:  begin a = 1; b = 1; end
      2:  begin a = 2; b = 1; end
      3:  begin mrd = 1; adr = 1; end
      4:  begin rw = 1; rs = 1; end
      5:  begin mwr = 1; adr = 1; end
      6:  begin a = 2; op = 2; end
      7:  begin a = 2; b = 1; op = 2; end
      8:  rw = 1;
      9:  begin a = 2; op = 1; pw = z; end
      10: begin a = 1; b = 2; pw = 1; end
      default: ;
    endcase
    return {pw, iw, adr, mrd, mwr, rw, a, b, op, rs};
  endfunction

  // compare process: checks DUT against the model on every falling edge
  always @(negedge clk_i) begin
    if (chk_en) begin
      if (exp_reset) begin
        chk("reset_enables", {27'd0, pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o}, 32'd0);
      end else begin
        chk("state", {28'd0, state_o}, exp_st);
        chk("ctrl", {17'd0, pc_write_o, ir_write_o, adr_src_o, mem_read_o, mem_write_o, reg_write_o,
                     alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o},
            {17'd0, exp_ctrl(exp_st, mem_ready_i, zero_i)});
        chk("instret", {24'd0, instret_o}, {24'd0, m_instret});
        chk("cause", {30'd0, cause_o}, {30'd0, m_cause});
        chk("trap", {31'd0, trap_o}, {31'd0, exp_st == 15});
      end
    end
  end

  task automatic step(input int st, input bit rdy, input bit z);
    exp_st = st;
    exp_reset = 1'b0;
    mem_ready_i = rdy;
    zero_i = z;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    exp_reset = 1'b1;
    mem_ready_i = 1'($urandom_range(0, 1));
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    exp_reset = 1'b0;
    m_instret = '0;
    m_cause = 2'b00;
  endtask

  // one wait state: n not-ready cycles, then ready unless n reaches the timeout
  task automatic wait_state(input int st, input int n, input bit z, output bit trapped);
    trapped = 1'b0;
    for (int i = 0; i < n && i < T; i++) step(st, 1'b0, z);
    if (n >= T) begin
      trapped = 1'b1;
      m_cause = 2'b10;
    end else begin
      step(st, 1'b1, z);
      if (st == 5) m_instret++;
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op == LW || op == SW || op == RR || op == II || op == BQ || op == JL;
  endfunction

  // whole instruction as an expected state path; leaves model in TRAP on illegal/timeout
  task automatic run_instr(input logic [6:0] op, input bit z, input int fw, input int mw);
    bit tr;
    opcode_i = op;
    wait_state(0, fw, z, tr);
    if (!tr) begin
      step(1, 1'($urandom_range(0, 1)), z);
      case (op)
        LW: begin
          step(2, 1'($urandom_range(0, 1)), z);
          wait_state(3, mw, z, tr);
          if (!tr) begin step(4, 1'($urandom_range(0, 1)), z); m_instret++; end
        end
        SW: begin
          step(2, 1'($urandom_range(0, 1)), z);
          wait_state(5, mw, z, tr);
        end
        RR: begin step(6, 1'($urandom_range(0, 1)), z); step(8, 1'($urandom_range(0, 1)), z); m_instret++; end
        II: begin step(7, 1'($urandom_range(0, 1)), z); step(8, 1'($urandom_range(0, 1)), z); m_instret++; end
        BQ: begin step(9, 1'($urandom_range(0, 1)), z); m_instret++; end
        JL: begin step(10, 1'($urandom_range(0, 1)), z); step(8, 1'($urandom_range(0, 1)), z); m_instret++; end
        default: begin tr = 1'b1; m_cause = 2'b01; end
      endcase
    end
    if (tr) repeat (3) step(15, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  function automatic logic [6:0] rand_legal();
    logic [6:0] ops [6];
    ops = '{LW, SW, RR, II, BQ, JL};
    return ops[$urandom_range(0, 5)];
  endfunction

  function automatic logic [6:0] rand_illegal();
    logic [6:0] op;
    op = 7'($urandom_range(0, 127));
    while (is_legal(op)) op = 7'($urandom_range(0, 127));
    return op;
  endfunction

  initial begin
    reset_i = 1'b1;
    opcode_i = RR;
    zero_i = 1'b0;
    mem_ready_i = 1'b0;
    exp_st = 0;
    exp_reset = 1'b1;
    chk_en = 1'b0;
    m_instret = '0;
    m_cause = 2'b00;
    @(posedge clk_i);
    #1;
    chk_en = 1'b1;
    do_reset();
    chk("reset_state_lit", {28'd0, state_o}, 32'd0);
    chk("reset_instret_lit", {24'd0, instret_o}, 32'd0);

    run_instr(RR, 1'b0, 0, 0);
    chk("add_instret_lit", {24'd0, instret_o}, 32'd1);
    run_instr(LW, 1'b0, 0, T - 1);
    chk("lw_wait_instret_lit", {24'd0, instret_o}, 32'd2);
    run_instr(LW, 1'b0, 0, T);
    chk("lw_timeout_trap_lit", {31'd0, trap_o}, 32'd1);
    chk("lw_timeout_cause_lit", {30'd0, cause_o}, 32'd2);
    do_reset();
    run_instr(BQ, 1'b1, 0, 0);
    run_instr(BQ, 1'b0, 0, 0);
    chk("beq_instret_lit", {24'd0, instret_o}, 32'd2);
    run_instr(7'b1111111, 1'b0, 0, 0);
    chk("illegal_cause_lit", {30'd0, cause_o}, 32'd1);
    do_reset();
    chk("illegal_reset_cause_lit", {30'd0, cause_o}, 32'd0);
    chk("illegal_reset_instret_lit", {24'd0, instret_o}, 32'd0);
    run_instr(JL, 1'b0, 0, 0);
    chk("jal_instret_lit", {24'd0, instret_o}, 32'd1);
    run_instr(SW, 1'b0, T - 1, T - 1);
    chk("sw_wait_instret_lit", {24'd0, instret_o}, 32'd2);

    // reset in the middle of a fetch wait must clear the wait counter
    opcode_i = RR;
    step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    do_reset();
    run_instr(RR, 1'b0, T - 1, 0);
    chk("midwait_reset_instret_lit", {24'd0, instret_o}, 32'd1);

    // long trap-free run so the narrow counter wraps
    for (int k = 0; k < 300; k++)
      run_instr(rand_legal(), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, T - 1) : 0,
                $urandom_range(0, T - 1));

    // mixed run including illegal opcodes and timeouts
    for (int k = 0; k < 200; k++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 15) == 0) ? rand_illegal() : rand_legal();
      run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, T), $urandom_range(0, T));
      if (m_cause != 2'b00) do_reset();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
